// File: rtl/nzcv_flag_unit.sv
// NZCV flag unit: computes flags in EX, carries them through M and W, commits
// at the end of W, and forwards the youngest in-flight flag value to the checker.
module nzcv_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic             ex_cond_pass,
  input  logic             ex_s,
  input  logic             ex_msr,
  input  logic [3:0]       ex_msr_nzcv,
  input  logic             ex_logic,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             ex_c,
  input  logic             ex_v,
  input  logic             ex_shift_c,
  input  logic             stall,
  input  logic             flush,
  output logic [3:0]       nzcv,
  output logic [3:0]       nzcv_fwd,
  output logic [1:0]       pending
);

  typedef struct packed {
    logic       wr;
    logic [3:0] flags;
  } stage_t;

  stage_t     m_stage;
  stage_t     w_stage;
  logic       ex_wr;
  logic [3:0] ex_flags;

  assign ex_wr = ex_valid & ex_cond_pass & (ex_s | ex_msr);

  // Youngest writer wins so a back-to-back dependent op sees the newest flags.
  assign nzcv_fwd = m_stage.wr ? m_stage.flags :
                    w_stage.wr ? w_stage.flags : nzcv;

  assign pending = {1'b0, m_stage.wr} + {1'b0, w_stage.wr};

  always_comb begin
    // NOTE: default every output of a combinational block first so no path
    // leaves it unassigned and a latch gets inferred.
    ex_flags = '0;
    if (ex_msr) begin
      ex_flags = ex_msr_nzcv;
    end else begin
      ex_flags[3] = ex_result[WIDTH-1];
      ex_flags[2] = (ex_result == '0);
      if (ex_logic) begin
        ex_flags[1] = ex_shift_c;
        ex_flags[0] = nzcv_fwd[0];  // V preserved from the newest older writer
      end else begin
        ex_flags[1] = ex_c;
        ex_flags[0] = ex_v;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values and W sees the old M, not the freshly written one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_stage <= '0;
      w_stage <= '0;
      nzcv    <= '0;
    end else if (!stall) begin
      m_stage.wr    <= ex_wr & ~flush;
      m_stage.flags <= ex_flags;
      w_stage.wr    <= m_stage.wr & ~flush;
      w_stage.flags <= m_stage.flags;
      if (w_stage.wr) nzcv <= w_stage.flags;
    end else if (flush) begin
      // A flush still kills the M entry while the rest of the pipe is frozen.
      m_stage.wr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_nzcv_flag_unit.sv
// Directed-vector bench for nzcv_flag_unit; stimulus queues the hand-computed
// outputs for each cycle and an independent monitor compares them.
module tb_nzcv_flag_unit;

  localparam int WIDTH = 32;

  typedef struct {
    logic             valid;
    logic             pass;
    logic             s;
    logic             msr;
    logic [3:0]       mnzcv;
    logic             lg;
    logic [WIDTH-1:0] result;
    logic             c;
    logic             v;
    logic             shc;
  } ex_t;

  typedef struct {
    int         row;
    logic [3:0] nzcv;
    logic [3:0] fwd;
    logic [1:0] pend;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             ex_valid = 1'b0;
  logic             ex_cond_pass = 1'b0;
  logic             ex_s = 1'b0;
  logic             ex_msr = 1'b0;
  logic [3:0]       ex_msr_nzcv = '0;
  logic             ex_logic = 1'b0;
  logic [WIDTH-1:0] ex_result = '0;
  logic             ex_c = 1'b0;
  logic             ex_v = 1'b0;
  logic             ex_shift_c = 1'b0;
  logic             stall = 1'b0;
  logic             flush = 1'b0;
  logic [3:0]       nzcv;
  logic [3:0]       nzcv_fwd;
  logic [1:0]       pending;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   row_n = 0;

  nzcv_flag_unit #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_cond_pass(ex_cond_pass),
    .ex_s(ex_s), .ex_msr(ex_msr), .ex_msr_nzcv(ex_msr_nzcv), .ex_logic(ex_logic),
    .ex_result(ex_result), .ex_c(ex_c), .ex_v(ex_v), .ex_shift_c(ex_shift_c),
    .stall(stall), .flush(flush), .nzcv(nzcv), .nzcv_fwd(nzcv_fwd), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic ex_t f_nop();
    ex_t e;
    e = '{valid: 1'b0, pass: 1'b0, s: 1'b0, msr: 1'b0, mnzcv: 4'b0, lg: 1'b0,
          result: '0, c: 1'b0, v: 1'b0, shc: 1'b0};
    return e;
  endfunction

  function automatic ex_t f_ar(input logic [WIDTH-1:0] res, input logic c, input logic v);
    ex_t e;
    e = f_nop();
    e.valid = 1'b1; e.pass = 1'b1; e.s = 1'b1;
    e.result = res; e.c = c; e.v = v;
    return e;
  endfunction

  function automatic ex_t f_lg(input logic [WIDTH-1:0] res, input logic shc);
    ex_t e;
    e = f_ar(res, 1'b1, 1'b0);  // ALU C/V deliberately disagree with expected flags
    e.lg = 1'b1; e.shc = shc;
    return e;
  endfunction

  function automatic ex_t f_msr(input logic [3:0] val, input logic s);
    ex_t e;
    e = f_ar('0, 1'b1, 1'b1);
    e.s = s; e.msr = 1'b1; e.mnzcv = val;
    return e;
  endfunction

  // One cycle: drive inputs just after the edge and queue the outputs expected
  // for this cycle (state left by the previous edge, or zeros under reset).
  task automatic cyc(input logic r, input logic st, input logic fl, input ex_t e,
                     input logic [3:0] en, input logic [3:0] ef, input logic [1:0] ep);
    exp_t x;
    @(posedge clk);
    #1;
    reset = r; stall = st; flush = fl;
    ex_valid = e.valid; ex_cond_pass = e.pass; ex_s = e.s; ex_msr = e.msr;
    ex_msr_nzcv = e.mnzcv; ex_logic = e.lg; ex_result = e.result;
    ex_c = e.c; ex_v = e.v; ex_shift_c = e.shc;
    row_n++;
    x = '{row: row_n, nzcv: en, fwd: ef, pend: ep};
    exp_q.push_back(x);
  endtask

  task automatic check(input string name, input int row, input logic [3:0] got,
                       input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%b expected=%b", name, row, got, want);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        check("nzcv", x.row, nzcv, x.nzcv);
        check("nzcv_fwd", x.row, nzcv_fwd, x.fwd);
        check("pending", x.row, {2'b00, pending}, {2'b00, x.pend});
      end
    end
  end

  initial begin : stimulus
    ex_t e;
    repeat (2) @(posedge clk);
    // Arithmetic latency: zero result, C=1 -> 0110, followed by writer 0010
    cyc(0, 0, 0, f_ar(32'h0, 1, 0),          4'b0000, 4'b0000, 0);
    cyc(0, 0, 0, f_ar(32'h1, 1, 0),          4'b0000, 4'b0110, 1);
    cyc(0, 0, 0, f_nop(),                    4'b0000, 4'b0010, 2);
    cyc(0, 0, 0, f_nop(),                    4'b0110, 4'b0010, 1);
    cyc(0, 0, 0, f_nop(),                    4'b0010, 4'b0010, 0);
    // Forwarding priority: A=1001 then B=0010
    cyc(0, 0, 0, f_ar(32'h8000_0000, 0, 1),  4'b0010, 4'b0010, 0);
    cyc(0, 0, 0, f_ar(32'h1, 1, 0),          4'b0010, 4'b1001, 1);
    cyc(0, 0, 0, f_nop(),                    4'b0010, 4'b0010, 2);
    cyc(0, 0, 0, f_nop(),                    4'b1001, 4'b0010, 1);
    cyc(0, 0, 0, f_nop(),                    4'b0010, 4'b0010, 0);
    // V-preserve from M (0001), then MSR 1010 overriding EX_S
    cyc(0, 0, 0, f_ar(32'h5, 0, 1),          4'b0010, 4'b0010, 0);
    cyc(0, 0, 0, f_lg(32'h0, 0),             4'b0010, 4'b0001, 1);
    cyc(0, 0, 0, f_msr(4'b1010, 1),          4'b0010, 4'b0101, 2);
    cyc(0, 0, 0, f_nop(),                    4'b0001, 4'b1010, 2);
    cyc(0, 0, 0, f_nop(),                    4'b0101, 4'b1010, 1);
    // V-preserve from committed NZCV (0011): logical N=1 shc=0 -> 1001
    cyc(0, 0, 0, f_msr(4'b0011, 0),          4'b1010, 4'b1010, 0);
    cyc(0, 0, 0, f_nop(),                    4'b1010, 4'b0011, 1);
    cyc(0, 0, 0, f_nop(),                    4'b1010, 4'b0011, 1);
    cyc(0, 0, 0, f_lg(32'h8000_0000, 0),     4'b0011, 4'b0011, 0);
    cyc(0, 0, 0, f_nop(),                    4'b0011, 4'b1001, 1);
    cyc(0, 0, 0, f_nop(),                    4'b0011, 4'b1001, 1);
    // Condition fail and invalid instruction are not writers
    e = f_ar(32'h0, 1, 1); e.pass = 1'b0;
    cyc(0, 0, 0, e,                          4'b1001, 4'b1001, 0);
    e = f_ar(32'h0, 1, 1); e.valid = 1'b0;
    cyc(0, 0, 0, e,                          4'b1001, 4'b1001, 0);
    cyc(0, 0, 0, f_nop(),                    4'b1001, 4'b1001, 0);
    cyc(0, 0, 0, f_nop(),                    4'b1001, 4'b1001, 0);
    // Stall for two cycles with M=1011, W=0100, then flush
    cyc(0, 0, 0, f_ar(32'h0, 0, 0),          4'b1001, 4'b1001, 0);
    cyc(0, 0, 0, f_ar(32'h8000_0000, 1, 1),  4'b1001, 4'b0100, 1);
    cyc(0, 1, 0, f_msr(4'b1111, 0),          4'b1001, 4'b1011, 2);
    cyc(0, 1, 0, f_msr(4'b1111, 0),          4'b1001, 4'b1011, 2);
    cyc(0, 0, 1, f_msr(4'b1111, 0),          4'b1001, 4'b1011, 2);
    cyc(0, 0, 0, f_nop(),                    4'b0100, 4'b0100, 0);
    cyc(0, 0, 0, f_nop(),                    4'b0100, 4'b0100, 0);
    cyc(0, 0, 0, f_nop(),                    4'b0100, 4'b0100, 0);
    // Flush during stall: M killed, W (0000) held then committed
    cyc(0, 0, 0, f_ar(32'h1, 0, 0),          4'b0100, 4'b0100, 0);
    cyc(0, 0, 0, f_ar(32'h0, 1, 1),          4'b0100, 4'b0000, 1);
    cyc(0, 1, 1, f_nop(),                    4'b0100, 4'b0111, 2);
    cyc(0, 0, 0, f_nop(),                    4'b0100, 4'b0000, 1);
    cyc(0, 0, 0, f_nop(),                    4'b0000, 4'b0000, 0);
    // Async reset with writers in M and W and nonzero NZCV
    cyc(0, 0, 0, f_msr(4'b1100, 0),          4'b0000, 4'b0000, 0);
    cyc(0, 0, 0, f_msr(4'b0011, 0),          4'b0000, 4'b1100, 1);
    cyc(0, 0, 0, f_msr(4'b1111, 0),          4'b0000, 4'b0011, 2);
    cyc(1, 0, 0, f_msr(4'b1010, 0),          4'b0000, 4'b0000, 0);
    cyc(0, 0, 0, f_nop(),                    4'b0000, 4'b0000, 0);
    cyc(0, 0, 0, f_nop(),                    4'b0000, 4'b0000, 0);
    cyc(0, 0, 0, f_nop(),                    4'b0000, 4'b0000, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
